// File: rtl/median3_stream_ctrl.sv
// 3-tap streaming median filter.
// Samples arrive over a valid/ready handshake, slide through a short tap
// history, and each full window is sorted into min/mid/max by a small
// comparator. The result sits in a single-entry output register with
// valid/ready back-pressure towards downstream logic.

// Three-input unsigned sorter: produces the smallest, middle and largest value.
module comp #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_mid,
    output logic [WIDTH-1:0] o_max
);

    logic [WIDTH-1:0] w_loAb;
    logic [WIDTH-1:0] w_hiAb;

    // Order the first pair, then place the third value relative to that pair.
    // The middle value is the third input clamped into [lo, hi] of the pair.
    assign w_loAb = (i_a < i_b) ? i_a : i_b;
    assign w_hiAb = (i_a < i_b) ? i_b : i_a;
    assign o_min  = (i_c < w_loAb) ? i_c : w_loAb;
    assign o_max  = (i_c > w_hiAb) ? i_c : w_hiAb;
    assign o_mid  = (i_c < w_loAb) ? w_loAb : ((i_c > w_hiAb) ? w_hiAb : i_c);

endmodule

// Streaming controller: window fill tracking, handshakes and output stage.
module median3_stream_ctrl #(
    parameter int WIDTH     = 7,
    parameter int EDGE_MODE = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_mid,
    output logic [WIDTH-1:0] out_max,
    output logic [1:0]       fill_cnt,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t           r_state;
    // Only the two newest history taps are stored: the sorter always sees the
    // post-shift window {tap1, tap2, in_data}, so the oldest tap would be
    // shifted out in the same edge it could have been used.
    logic [WIDTH-1:0] r_tap1;
    logic [WIDTH-1:0] r_tap2;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outMin;
    logic [WIDTH-1:0] r_outMid;
    logic [WIDTH-1:0] r_outMax;
    logic [1:0]       r_fillCnt;
    logic [CNT_W-1:0] r_outCnt;

    logic             w_inReady;
    logic             w_accept;
    logic             w_edgeFirst;
    logic             w_load;
    logic [WIDTH-1:0] w_compA;
    logic [WIDTH-1:0] w_compB;
    logic [WIDTH-1:0] w_min;
    logic [WIDTH-1:0] w_mid;
    logic [WIDTH-1:0] w_max;

    // A sample is taken only when the output slot is free or retiring this
    // cycle; a flush blocks acceptance so no sample vanishes into a cleared window.
    assign w_inReady   = !flush && (!r_outValid || out_ready);
    assign w_accept    = in_valid && w_inReady;
    // In edge-replication mode the very first sample stands in for all taps.
    assign w_edgeFirst = (EDGE_MODE != 0) && (r_state == EMPTY);
    assign w_load      = w_accept && ((r_state == FILL2) || (r_state == RUN) || w_edgeFirst);
    assign w_compA     = w_edgeFirst ? in_data : r_tap1;
    assign w_compB     = w_edgeFirst ? in_data : r_tap2;

    comp #(
        .WIDTH(WIDTH)
    ) u_comp (
        .i_a  (w_compA),
        .i_b  (w_compB),
        .i_c  (in_data),
        .o_min(w_min),
        .o_mid(w_mid),
        .o_max(w_max)
    );

    // Window fill FSM, tap shifting and single-entry output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_tap1     <= '0;
            r_tap2     <= '0;
            r_outValid <= 1'b0;
            r_outMin   <= '0;
            r_outMid   <= '0;
            r_outMax   <= '0;
            r_fillCnt  <= 2'd0;
            r_outCnt   <= '0;
        end else if (flush) begin
            r_state    <= EMPTY;
            r_fillCnt  <= 2'd0;
            r_outValid <= 1'b0;
            r_outCnt   <= '0;
        end else begin
            if (w_accept) begin
                if (w_edgeFirst) begin
                    r_tap1    <= in_data;
                    r_tap2    <= in_data;
                    r_state   <= RUN;
                    r_fillCnt <= 2'd3;
                end else begin
                    r_tap1 <= r_tap2;
                    r_tap2 <= in_data;
                    case (r_state)
                        EMPTY: begin
                            r_state   <= FILL1;
                            r_fillCnt <= 2'd1;
                        end
                        FILL1: begin
                            r_state   <= FILL2;
                            r_fillCnt <= 2'd2;
                        end
                        default: begin
                            r_state   <= RUN;
                            r_fillCnt <= 2'd3;
                        end
                    endcase
                end
            end
            if (w_load) begin
                r_outMin   <= w_min;
                r_outMid   <= w_mid;
                r_outMax   <= w_max;
                r_outValid <= 1'b1;
                r_outCnt   <= r_outCnt + CNT_W'(1);
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign out_min   = r_outMin;
    assign out_mid   = r_outMid;
    assign out_max   = r_outMax;
    assign fill_cnt  = r_fillCnt;
    assign out_cnt   = r_outCnt;

endmodule
